wave_ctrl: RTL

//  Front-panel controller for the function generator waveform datapaths (sine/square/tan/... ROM readers).

---
 rtl/wave_ctrl_pkg.sv | 40 ++++
 rtl/wave_ctrl_if.sv | 34 +++
 rtl/wave_ctrl_btn_cond.sv | 74 +++++++
 rtl/wave_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/wave_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | wave_ctrl_pkg                                                              |
// | Shared types, function codes and helpers for the waveform control block.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package wave_ctrl_pkg;

  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] FUNC_SINE   = 3'd0;
  localparam logic [CNT_W-1:0] FUNC_SQUARE = 3'd1;
  localparam logic [CNT_W-1:0] FUNC_TAN    = 3'd2;
  localparam logic [CNT_W-1:0] FUNC_TRI    = 3'd3;
  localparam logic [CNT_W-1:0] FUNC_SAW    = 3'd4;

  // Prescaler value that no datapath treats as "step", so ROM readers stall
  localparam logic [CNT_W-1:0] FREEZE_DY = 3'd7;

  localparam int NUM_BTN  = 4;
  localparam int BTN_FUNC = 0;
  localparam int BTN_FREQ = 1;
  localparam int BTN_AMP  = 2;
  localparam int BTN_PERI = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] val,
                                                input logic [CNT_W-1:0] max_val);
    return (val >= max_val) ? '0 : val + CNT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wave_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | wave_ctrl_if                                                               |
// | Front-panel buttons and the shared waveform control bus.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

interface wave_ctrl_if;
  import wave_ctrl_pkg::*;

  logic             btn_func;
  logic             btn_freq;
  logic             btn_amp;
  logic             btn_peri;
  logic [CNT_W-1:0] func_cnt;
  logic [CNT_W-1:0] freq_dy;
  logic [CNT_W-1:0] amp_cnt;
  logic [CNT_W-1:0] peri_cnt;
  logic [CNT_W-1:0] peri_posedge;
  logic             busy;

  modport master (
    input  btn_func, btn_freq, btn_amp, btn_peri,
    output func_cnt, freq_dy, amp_cnt, peri_cnt, peri_posedge, busy
  );

  modport slave (
    output btn_func, btn_freq, btn_amp, btn_peri,
    input  func_cnt, freq_dy, amp_cnt, peri_cnt, peri_posedge, busy
  );

endinterface

`default_nettype wire

// File: rtl/wave_ctrl_btn_cond.sv
// +----------------------------------------------------------------------------+
// | btn_cond                                                                   |
// | Push-button conditioner: 2-flop sync, optional debounce, rising-edge strobe|
// | Debounce enabled by defining WAVE_CTRL_DEBOUNCE_EN.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_cond #(
  parameter int DB_CYC = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic btn,
  output logic      press
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_press;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef WAVE_CTRL_DEBOUNCE_EN
  localparam int DB_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;

  // Level only follows after DB_CYC consecutive samples disagree with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (r_sync2 == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYC - 1)) begin
      r_db_cnt   <= '0;
      r_db_level <= r_sync2;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  assign w_level = r_db_level;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= w_level & ~r_level_d;
    end
  end

  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/wave_ctrl.sv
// +----------------------------------------------------------------------------+
// | wave_ctrl                                                                  |
// | Front-panel controller: button strobes -> counts, prescaler, APPLY/HOLD.   |
// | Optional debounce via WAVE_CTRL_DEBOUNCE_EN (in btn_cond).                 |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module wave_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int NUM_FUNC = 5,
  parameter int MAX_FREQ = 7,
  parameter int MAX_AMP  = 3,
  parameter int MAX_PERI = 3,
  parameter int HOLD_CYC = 16,
  parameter int DB_CYC   = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  wave_ctrl_if.master bus
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_press;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_func_cnt, w_func_nxt;
  logic [CNT_W-1:0]   r_freq_cnt, w_freq_nxt;
  logic [CNT_W-1:0]   r_amp_cnt,  w_amp_nxt;
  logic [CNT_W-1:0]   r_peri_cnt, w_peri_nxt;
  logic [CNT_W-1:0]   r_freq_dy,  w_dy_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic               r_pulse,    w_pulse_nxt;
  logic               r_busy,     w_busy_nxt;

  assign w_btn_raw = {bus.btn_peri, bus.btn_amp, bus.btn_freq, bus.btn_func};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_cond #(.DB_CYC(DB_CYC)) u_btn (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (w_btn_raw[gi]),
      .press (w_press[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (|w_press)           w_state_nxt = APPLY;
      APPLY:                           w_state_nxt = HOLD;
      HOLD:    if (r_hold_cnt == '0)   w_state_nxt = RUN;
      default:                         w_state_nxt = RUN;
    endcase
  end

  // Next values for every registered output; strobes outside RUN fall through
  always_comb begin
    w_func_nxt  = r_func_cnt;
    w_freq_nxt  = r_freq_cnt;
    w_amp_nxt   = r_amp_cnt;
    w_peri_nxt  = r_peri_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_dy_nxt    = '0;
    w_pulse_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_press[BTN_FUNC])      w_func_nxt = wrap_inc(r_func_cnt, CNT_W'(NUM_FUNC - 1));
        else if (w_press[BTN_PERI]) w_peri_nxt = wrap_inc(r_peri_cnt, CNT_W'(MAX_PERI));
        else if (w_press[BTN_AMP])  w_amp_nxt  = wrap_inc(r_amp_cnt,  CNT_W'(MAX_AMP));
        else if (w_press[BTN_FREQ]) w_freq_nxt = wrap_inc(r_freq_cnt, CNT_W'(MAX_FREQ));

        if (|w_press) begin
          w_pulse_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_dy_nxt = wrap_inc(r_freq_dy, r_freq_cnt);
        end
      end
      APPLY: begin
        w_hold_nxt = HOLD_W'(HOLD_CYC - 1);
        w_dy_nxt   = FREEZE_DY;
        w_busy_nxt = 1'b1;
      end
      HOLD: begin
        if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - HOLD_W'(1);
          w_dy_nxt   = FREEZE_DY;
          w_busy_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func_cnt <= FUNC_SINE;
      r_freq_cnt <= '0;
      r_amp_cnt  <= '0;
      r_peri_cnt <= '0;
      r_freq_dy  <= '0;
      r_hold_cnt <= '0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_func_cnt <= w_func_nxt;
      r_freq_cnt <= w_freq_nxt;
      r_amp_cnt  <= w_amp_nxt;
      r_peri_cnt <= w_peri_nxt;
      r_freq_dy  <= w_dy_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_pulse    <= w_pulse_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign bus.func_cnt     = r_func_cnt;
  assign bus.freq_dy      = r_freq_dy;
  assign bus.amp_cnt      = r_amp_cnt;
  assign bus.peri_cnt     = r_peri_cnt;
  assign bus.peri_posedge = {2'b00, r_pulse};
  assign bus.busy         = r_busy;

endmodule

`default_nettype wire
